comp_serial: RTL

COMP_SERIAL -- requirements
Module: comp_serial

---
 rtl/comp_serial.sv | 131 +++++++++++++
 1 files changed

// File: rtl/comp_serial.sv
// Serial magnitude comparator: walks DW-bit operands MSB-first, CW bits per cycle, with early exit.
// Define COMP_SERIAL_SIGNED_EN to compare operands as two's complement.
module comp_serial #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          lt,
    output logic          eq,
    output logic          gt
);

    localparam int unsigned NC   = DW / CW;
    localparam int unsigned CNTW = $clog2(NC + 1);
    localparam logic [CNTW-1:0] NC_C  = CNTW'(NC);
    localparam logic [CNTW-1:0] ONE_C = CNTW'(1);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic [DW-1:0]   a_shl, b_shl;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
    logic [CW-1:0]   ca, cb;

    generate
        if (DW > CW) begin : g_shift
            assign a_shl = {a_q[DW-CW-1:0], {CW{1'b0}}};
            assign b_shl = {b_q[DW-CW-1:0], {CW{1'b0}}};
        end else begin : g_noshift
            assign a_shl = '0;
            assign b_shl = '0;
        end
    endgenerate

    always_comb begin
        ca = a_q[DW-1 -: CW];
        cb = b_q[DW-1 -: CW];
`ifdef COMP_SERIAL_SIGNED_EN
        // Flipping the sign bit of the top chunk maps two's complement order onto unsigned order.
        if (cnt_q == NC_C) begin
            ca[CW-1] = ~ca[CW-1];
            cb[CW-1] = ~cb[CW-1];
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = NC_C;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (ca < cb) begin
                    lt_d    = 1'b1;
                    state_d = DONE;
                end else if (ca > cb) begin
                    gt_d    = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == ONE_C) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    a_d   = a_shl;
                    b_d   = b_shl;
                    cnt_d = cnt_q - ONE_C;
                end
            end
            DONE: begin
                if (out_ready) begin
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign gt        = gt_q;

endmodule
